// File: rtl/encoder_tx_ctrl.sv
// Transmit sequencer for the bipolar line encoder: frames payload words
// as sync pattern, MSB-first payload and an idle gap, one bit per clk.
//
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   enable           low aborts the frame and holds the encoder in reset
//   start, len       frame request and its payload word count
//   s_data, s_valid  payload word source
//   s_ready          word taken at this edge (one cycle per word slot)
//   enc_data         serial bit to the encoder
//   enc_reset        encoder reset, registered ~enable
//   busy, done       frame in progress / one-cycle completion pulse
//   underrun         sticky, a word slot found s_valid low
module encoder_tx_ctrl #(
  parameter int WIDTH = 8,
  parameter int SYNC_LEN = 8,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = 8'hA5,
  parameter int GAP_LEN = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             enc_data,
  output logic             enc_reset,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  localparam int M1 =
    (WIDTH > SYNC_LEN) ? WIDTH : SYNC_LEN;
  localparam int CNT_MAX =
    (M1 > GAP_LEN) ? M1 : GAP_LEN;
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SYNC_LAST =
    CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] WORD_LAST =
    CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    PAYLOAD,
    GAP
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [LEN_W-1:0]   words_left;
  logic [LEN_W-1:0]   words_nxt;
  logic [WIDTH-1:0]   shreg;
  logic [WIDTH-1:0]   sh_nxt;
  logic [SYNC_LEN-1:0] sync_sr;
  logic [SYNC_LEN-1:0] sync_nxt;
  logic               load;

  logic enc_data_nxt;
  logic enc_reset_nxt;
  logic s_ready_nxt;
  logic busy_nxt;
  logic done_nxt;
  logic underrun_nxt;

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      words_left <= '0;
      shreg      <= '0;
      sync_sr    <= '0;
      enc_data   <= 1'b0;
      enc_reset  <= 1'b1;
      s_ready    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      words_left <= words_nxt;
      shreg      <= sh_nxt;
      sync_sr    <= sync_nxt;
      enc_data   <= enc_data_nxt;
      enc_reset  <= enc_reset_nxt;
      s_ready    <= s_ready_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      underrun   <= underrun_nxt;
    end
  end

  // Next state. The bit on the line in a cycle is the MSB
  // of the active shift register; words_left still counts
  // the word being sent until its last bit leaves.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    words_nxt = words_left;
    sh_nxt    = shreg;
    sync_nxt  = sync_sr;
    load      = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state_nxt = SYNC;
            cnt_nxt   = '0;
            words_nxt = len;
            sync_nxt  = SYNC_PATTERN;
          end
        end
        SYNC: begin
          if (cnt == SYNC_LAST) begin
            if (words_left != '0) begin
              load = 1'b1;
            end else begin
              state_nxt = GAP;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt  = cnt + CNT_W'(1);
            sync_nxt = sync_sr << 1;
          end
        end
        PAYLOAD: begin
          if (cnt == WORD_LAST) begin
            words_nxt = words_left - LEN_W'(1);
            if (words_left == LEN_W'(1)) begin
              state_nxt = GAP;
              cnt_nxt   = '0;
            end else begin
              load = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
            sh_nxt  = shreg << 1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
      // Word slot: a missing word is replaced by zeros,
      // the frame never stalls.
      if (load) begin
        state_nxt = PAYLOAD;
        cnt_nxt   = '0;
        sh_nxt    = s_valid ? s_data : '0;
      end
    end
  end

  // Output values for the next cycle.
  always_comb begin
    enc_data_nxt = 1'b0;
    unique case (state_nxt)
      SYNC:    enc_data_nxt = sync_nxt[SYNC_LEN-1];
      PAYLOAD: enc_data_nxt = sh_nxt[WIDTH-1];
      default: enc_data_nxt = 1'b0;
    endcase
    // Ready rides on the last bit of the current item,
    // only when another word follows it.
    s_ready_nxt =
      (state_nxt == SYNC && cnt_nxt == SYNC_LAST &&
       words_nxt != '0) ||
      (state_nxt == PAYLOAD && cnt_nxt == WORD_LAST &&
       words_nxt > LEN_W'(1));
    busy_nxt = (state_nxt != IDLE);
    done_nxt = enable && state == GAP &&
               cnt == GAP_LAST;
    enc_reset_nxt = ~enable;
    underrun_nxt = underrun;
    if (enable && state == IDLE && start) begin
      underrun_nxt = 1'b0;
    end else if (load && !s_valid) begin
      underrun_nxt = 1'b1;
    end
  end

endmodule

// File: tb/tb_encoder_tx_ctrl.sv
// Testbench for encoder_tx_ctrl: position-based frame model checked
// every cycle, directed frames with literal expectations, random traffic.
module tb_encoder_tx_ctrl;

  localparam int S = 8;
  localparam int W = 8;
  localparam int G = 4;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       start;
  logic [7:0] len;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;
  logic       enc_data;
  logic       enc_reset;
  logic       busy;
  logic       done;
  logic       underrun;

  encoder_tx_ctrl dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .start(start),
    .len(len),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .enc_data(enc_data),
    .enc_reset(enc_reset),
    .busy(busy),
    .done(done),
    .underrun(underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit mon_en = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Frame model: position p counts cycles since the
  // accepted start (first sync bit at p=1).
  logic [7:0] pat = 8'hA5;
  bit         m_act = 0;
  int         m_p = 0;
  int         m_len = 0;
  logic [7:0] m_words[$];
  logic e_enc = 0;
  logic e_rdy = 0;
  logic e_busy = 0;
  logic e_done = 0;
  logic e_und = 0;
  logic e_erst = 1;

  function automatic logic m_ready(int p, int ln);
    return p >= S && (p - S) % W == 0 &&
           (p - S) / W < ln;
  endfunction

  function automatic logic m_bit(int p);
    int q;
    logic [7:0] w;
    if (p <= S) return pat[S-p];
    if (p <= S + m_len * W) begin
      q = p - S - 1;
      w = m_words[q / W];
      return w[W-1-(q % W)];
    end
    return 1'b0;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_act = 0;
        e_und = 0;
        e_erst = 1;
        e_done = 0;
      end else begin
        e_erst = !enable;
        e_done = 0;
        if (!enable) begin
          m_act = 0;
        end else if (m_act) begin
          if (m_ready(m_p, m_len)) begin
            m_words.push_back(s_valid ? s_data : 8'h00);
            if (!s_valid) e_und = 1;
          end
          m_p++;
          if (m_p == S + m_len * W + G + 1) begin
            m_act = 0;
            e_done = 1;
          end
        end else if (start) begin
          m_act = 1;
          m_p = 1;
          m_len = int'(len);
          m_words.delete();
          e_und = 0;
        end
      end
      e_busy = m_act;
      e_rdy = m_act && m_ready(m_p, m_len);
      e_enc = m_act ? m_bit(m_p) : 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("m_enc_data", enc_data, e_enc);
        chk("m_s_ready", s_ready, e_rdy);
        chk("m_busy", busy, e_busy);
        chk("m_done", done, e_done);
        chk("m_underrun", underrun, e_und);
        chk("m_enc_reset", enc_reset, e_erst);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic run_frame(input int ln, input int ncyc,
                           input logic [7:0] w0,
                           input logic [7:0] w1,
                           input logic v,
                           output logic [63:0] bits,
                           output int r1, output int r2,
                           output int nr, output int dcyc);
    logic pr;
    @(negedge clk);
    len = 8'(ln);
    start = 1;
    s_data = w0;
    s_valid = v;
    @(posedge clk);
    bits = '0;
    nr = 0;
    r1 = -1;
    r2 = -1;
    dcyc = -1;
    pr = 0;
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      if (pr) s_data = w1;
      pr = s_ready;
      bits = {bits[62:0], enc_data};
      if (s_ready) begin
        if (nr == 0) r1 = c;
        else r2 = c;
        nr++;
      end
      if (done && dcyc < 0) dcyc = c;
    end
  endtask

  logic [63:0] bits;
  int r1, r2, nr, dc, d1, d2;

  initial begin
    reset = 1;
    enable = 1;
    start = 0;
    len = 0;
    s_data = 0;
    s_valid = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    mon_en = 1;
    chk("rst_enc_reset", enc_reset, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enc_data", enc_data, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    reset = 0;
    @(negedge clk);
    chk("rel_enc_reset", enc_reset, 0);

    // Two words, full handshake.
    run_frame(2, 30, 8'h3C, 8'hF0, 1,
              bits, r1, r2, nr, dc);
    chk("t1_bits", bits[29:0],
        30'b101001010011110011110000000000);
    chk("t1_rdy1", r1, 8);
    chk("t1_rdy2", r2, 16);
    chk("t1_nrdy", nr, 2);
    chk("t1_done", dc, 29);
    chk("t1_underrun", underrun, 0);

    // Empty frame.
    run_frame(0, 14, 8'h00, 8'h00, 1,
              bits, r1, r2, nr, dc);
    chk("t2_bits", bits[13:0], 14'b10100101000000);
    chk("t2_nrdy", nr, 0);
    chk("t2_done", dc, 13);

    // Missing word.
    run_frame(1, 20, 8'hFF, 8'hFF, 0,
              bits, r1, r2, nr, dc);
    chk("t3_bits", bits[19:0], 20'hA5000);
    chk("t3_underrun", underrun, 1);
    @(negedge clk);
    @(negedge clk);
    start = 1;
    len = 0;
    s_valid = 1;
    @(posedge clk);
    @(negedge clk);
    start = 0;
    chk("t3_clear", underrun, 0);
    repeat (14) @(negedge clk);

    // Abort by enable mid-frame.
    len = 3;
    start = 1;
    @(posedge clk);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) start = 0;
      s_data = 8'($urandom);
      if (c == 11) begin
        chk("t4_enc_data", enc_data, 0);
        chk("t4_busy", busy, 0);
        chk("t4_enc_reset", enc_reset, 1);
        chk("t4_s_ready", s_ready, 0);
      end
      if (c >= 11) chk("t4_no_done", done, 0);
      if (c == 10) enable = 0;
    end
    enable = 1;
    repeat (3) @(negedge clk);

    // Back-to-back frames with start held.
    len = 1;
    start = 1;
    @(posedge clk);
    d1 = -1;
    d2 = -1;
    for (int c = 1; c <= 50; c++) begin
      @(negedge clk);
      s_data = 8'($urandom);
      if (d1 > 0 && c == d1 + 1) begin
        chk("t5_first_sync", enc_data, 1);
        chk("t5_busy", busy, 1);
      end
      if (done) begin
        if (d1 < 0) d1 = c;
        else if (d2 < 0) d2 = c;
      end
    end
    start = 0;
    chk("t5_done1", d1, 21);
    chk("t5_done2", d2, 42);
    repeat (25) @(negedge clk);

    // Start during busy is ignored.
    len = 2;
    start = 1;
    @(posedge clk);
    dc = -1;
    nr = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      s_data = 8'($urandom);
      if (c == 1) start = 0;
      if (c == 5) begin
        start = 1;
        len = 7;
      end
      if (c == 8) start = 0;
      if (s_ready) nr++;
      if (done && dc < 0) dc = c;
    end
    chk("t6_nrdy", nr, 2);
    chk("t6_done", dc, 29);

    // Maximum length.
    len = 8'hFF;
    start = 1;
    @(posedge clk);
    dc = -1;
    for (int c = 1; c <= 2100; c++) begin
      @(negedge clk);
      start = 0;
      s_data = 8'($urandom);
      if (done) begin
        dc = c;
        break;
      end
    end
    chk("t7_done", dc, S + 255 * W + G + 1);
    repeat (3) @(negedge clk);

    // Random traffic.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      reset = ($urandom_range(0, 299) == 0);
      enable = ($urandom_range(0, 79) != 0);
      start = ($urandom_range(0, 5) == 0);
      len = 8'($urandom_range(0, 3));
      s_valid = ($urandom_range(0, 9) != 0);
      s_data = 8'($urandom);
    end
    reset = 0;
    enable = 1;
    start = 0;
    repeat (60) @(negedge clk);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
